// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU. Single-cycle logic/arith/shift ops, plus an
//               iterative shift-add multiplier and restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [3:0]       op_q, op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] sum, diff, quick_res;
    logic             quick_ovf, iterate, accept;
    logic [WIDTH-1:0] mul_acc, rem_next, quo_next, fin_res;
    logic [WIDTH:0]   trial;
    logic             qbit, last;

    always_comb begin
        sum       = A + B;
        diff      = A - B;
        quick_res = '0;
        quick_ovf = 1'b0;
        case (ALUop)
            4'b0000: begin
                quick_res = sum;
                quick_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0001: begin
                quick_res = diff;
                quick_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0010: quick_res = A & B;
            4'b0011: quick_res = A | B;
            4'b0100: quick_res = {{(WIDTH-1){1'b0}}, (A < B)};
            4'b0101: quick_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b0110: quick_res = A ^ B;
            4'b0111: quick_res = ~(A | B);
            4'b1000: quick_res = A << B[SHW-1:0];
            4'b1001: quick_res = A >> B[SHW-1:0];
            4'b1010: quick_res = $unsigned($signed(A) >>> B[SHW-1:0]);
            // Only reached with B == 0; nonzero divisors take the iterative path.
            4'b1100: quick_res = '1;
            4'b1101: quick_res = A;
            default: quick_res = '0;
        endcase
    end

    assign iterate = (ALUop == OP_MUL) ||
                     (((ALUop == OP_DIVU) || (ALUop == OP_REMU)) && (B != '0));
    assign accept  = start && (state_q != S_CALC);

    // acc_q holds the product sum (MUL) or partial remainder (DIVU/REMU);
    // a_q shifts out dividend bits while shifting in quotient bits.
    assign mul_acc  = acc_q + (b_q[0] ? a_q : '0);
    assign trial    = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
    assign qbit     = ~trial[WIDTH];
    assign rem_next = qbit ? trial[WIDTH-1:0] : {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
    assign quo_next = {a_q[WIDTH-2:0], qbit};
    assign last     = (cnt_q == SHW'(WIDTH-1));
    assign fin_res  = (op_q == OP_MUL)  ? mul_acc :
                      (op_q == OP_DIVU) ? quo_next : rem_next;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = rem_next;
                    a_d   = quo_next;
                end
                if (last) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = fin_res;
                    zero_d   = (fin_res == '0);
                    ovf_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (iterate) begin
                        state_d = S_CALC;
                        a_d     = A;
                        b_d     = B;
                        op_d    = ALUop;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d  = S_DONE;
                        result_d = quick_res;
                        zero_d   = (quick_res == '0);
                        ovf_d    = quick_ovf;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy     = (state_q == S_CALC);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Scoreboard bench for alu_mc with directed, hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] A, B;
    logic [3:0]   ALUop;
    logic         busy, done, zero, overflow;
    logic [W-1:0] result;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .ALUop(ALUop),
        .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         o;
        int unsigned  at;
        string        nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_done: got result %h at cycle %0d, expected no done", result, cyc);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || zero !== e.z || overflow !== e.o || cyc != e.at) begin
                    n_miss++;
                    $display("FAIL %s: got res=%h z=%b ovf=%b cyc=%0d expected res=%h z=%b ovf=%b cyc=%0d",
                             e.nm, result, zero, overflow, cyc, e.res, e.z, e.o, e.at);
                end
            end
        end
    end

    task automatic issue(string nm, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] res, logic z, logic o, int lat);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_wait: busy stuck at %b, expected 0", nm, busy);
        end
        sb.push_back('{res, z, o, cyc + lat, nm});
        start = 1'b1;
        ALUop = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        ALUop = 4'($urandom);
    endtask

    task automatic drain(string nm);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", nm, sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b1;
        ALUop = 4'b0000;
        A     = 32'd1;
        B     = 32'd1;
        repeat (3) @(negedge clk);
        chk("reset_flags", {28'd0, busy, done, zero, overflow}, 32'h2);
        chk("reset_result", result, 32'h0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        issue("add_ovf",  4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1);
        issue("sub_zero", 4'b0001, 32'd5,        32'd5, 32'h0,        1'b1, 1'b0, 1);
        issue("sub_ovf",  4'b0001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1);
        issue("slt",      4'b0101, 32'hFFFFFFFF, 32'h1, 32'h1,        1'b0, 1'b0, 1);
        issue("sltu",     4'b0100, 32'hFFFFFFFF, 32'h1, 32'h0,        1'b1, 1'b0, 1);
        issue("and",      4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1);
        issue("or",       4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1);
        issue("xor",      4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1);
        issue("nor",      4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0, 1);
        issue("sll",      4'b1000, 32'h1,        32'd31, 32'h80000000, 1'b0, 1'b0, 1);
        issue("sll_amt",  4'b1000, 32'h1,        32'h21, 32'h2,        1'b0, 1'b0, 1);
        issue("op_1110",  4'b1110, 32'h12345678, 32'h1, 32'h0,        1'b1, 1'b0, 1);
        issue("sra",      4'b1010, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        issue("srl_b2b",  4'b1001, 32'h80000000, 32'd31, 32'h00000001, 1'b0, 1'b0, 1);
        drain("single");

        issue("mul", 4'b1011, 32'h00010000, 32'h00010003, 32'h00030000, 1'b0, 1'b0, 33);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 5) begin
                start = 1'b1;
                ALUop = 4'b0000;
                A     = 32'd1;
                B     = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("mul_busy_cycles", n, 32);
        issue("mul_ones", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 33);
        issue("divu",     4'b1100, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
        issue("remu",     4'b1101, 32'd100, 32'd7, 32'd2,  1'b0, 1'b0, 33);
        issue("divu_z",   4'b1100, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        issue("remu_z",   4'b1101, 32'd9,   32'd0, 32'd9,  1'b0, 1'b0, 1);
        drain("multi");

        start = 1'b1;
        ALUop = 4'b1100;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_flags", {28'd0, busy, done, zero, overflow}, 32'h2);
        chk("abort_result", result, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        issue("add_post", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);
        drain("post");

        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
